// File: rtl/ccff_config_loader.sv
// Serial bitstream loader for a ble6 configuration chain (LUT6 + output mux).
// Define CCFF_READBACK_EN to add a recirculating ones-count readback check.
module ccff_config_loader #(
    parameter int CHAIN_LEN = 66,
    parameter int BYTE_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [BYTE_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic              ccff_tail,
    output logic              ccff_head,
    output logic              shift_en,
    output logic              busy,
    output logic              cfg_done,
    output logic              cfg_error
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int RW = $clog2(BYTE_W + 1);
    localparam logic [CW-1:0] LAST  = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] FULL  = CW'(CHAIN_LEN);
    localparam logic [RW-1:0] WBITS = RW'(BYTE_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BYTE_W-1:0] buf_q, buf_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic              shift_q, shift_d;
    logic              head_q, head_d;
    logic              ready, accept;

`ifdef CCFF_READBACK_EN
    logic [CW-1:0] ones_ld_q, ones_ld_d;
    logic [CW-1:0] ones_rb_q, ones_rb_d;
    logic          err_q, err_d;
`endif

    // rem_q counts bits still waiting in buf_q behind the one on head_q
    assign ready  = (state_q == LOAD) && !shift_q
                    && (rem_q == '0) && (cnt_q < FULL);
    assign accept = ready && cfg_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        head_d  = head_q;
`ifdef CCFF_READBACK_EN
        ones_ld_d = ones_ld_q;
        ones_rb_d = ones_rb_q;
        err_d     = err_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (cfg_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    shift_d = 1'b0;
                    rem_d   = '0;
`ifdef CCFF_READBACK_EN
                    ones_ld_d = '0;
                    err_d     = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (shift_q) begin
                    cnt_d = cnt_q + CW'(1);
`ifdef CCFF_READBACK_EN
                    ones_ld_d = ones_ld_q + CW'(head_q);
`endif
                    if (cnt_q == LAST) begin
                        shift_d = 1'b0;
                        rem_d   = '0;
`ifdef CCFF_READBACK_EN
                        state_d   = VERIFY;
                        cnt_d     = '0;
                        ones_rb_d = '0;
`else
                        state_d = DONE;
`endif
                    end else if (rem_q != '0) begin
                        shift_d = 1'b1;
                        head_d  = buf_q[BYTE_W-1];
                        buf_d   = buf_q << 1;
                        rem_d   = rem_q - RW'(1);
                    end else begin
                        shift_d = 1'b0;
                    end
                end else if (accept) begin
                    shift_d = 1'b1;
                    head_d  = cfg_data[BYTE_W-1];
                    buf_d   = cfg_data << 1;
                    rem_d   = WBITS;
                end
            end
            VERIFY: begin
`ifdef CCFF_READBACK_EN
                cnt_d     = cnt_q + CW'(1);
                head_d    = ccff_tail;
                ones_rb_d = ones_rb_q + CW'(ccff_tail);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cnt_d   = FULL;
                    err_d   = (ones_ld_q != ones_rb_d);
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (cfg_abort) begin
            state_d = IDLE;
            shift_d = 1'b0;
            rem_d   = '0;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!prog_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            rem_q   <= '0;
            shift_q <= 1'b0;
            head_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
            ones_ld_q <= '0;
            ones_rb_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            head_q  <= head_d;
`ifdef CCFF_READBACK_EN
            ones_ld_q <= ones_ld_d;
            ones_rb_q <= ones_rb_d;
            err_q     <= err_d;
`endif
        end
    end

    // VERIFY recirculates the chain so its contents survive the readback
    assign cfg_ready = prog_reset & ready;
    assign shift_en  = prog_reset & (shift_q | (state_q == VERIFY));
    assign ccff_head = prog_reset
                       & ((state_q == VERIFY) ? ccff_tail : head_q);
    assign busy      = prog_reset
                       & ((state_q == LOAD) | (state_q == VERIFY));
    assign cfg_done  = prog_reset & (state_q == DONE);
`ifdef CCFF_READBACK_EN
    assign cfg_error = prog_reset & err_q;
`else
    assign cfg_error = 1'b0;
`endif

endmodule
